// File: rtl/fir_capture_pkg.sv
// Shared types and constants for the FIR output-stream capture buffer.
package fir_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  // Mode 3 is reserved and behaves like an immediate trigger.
  function automatic logic trig_is_immediate(input logic [1:0] mode);
    return (mode == TRIG_IMM) || ((mode != TRIG_RISE) && (mode != TRIG_FALL));
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module capture_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; array is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port, one cycle latency; a same-cycle write returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_stream_capture.sv
// Triggered, frame-decimated capture of a TDM AXI-stream into on-chip RAM.
module fir_stream_capture
  import fir_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              aclk_0,
  input  logic              aresetn_0,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]   s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [CH_W-1:0]   trig_ch,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [15:0]       decim,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (1 << ADDR_W) != DEPTH ||
      NUM_CH < 1 || NUM_CH > (1 << CH_W)) begin : g_bad_params
    $error("fir_stream_capture: inconsistent DEPTH/ADDR_W/NUM_CH/CH_W");
  end

  cap_state_e               state_q;
  logic                     busy_q, done_q;
  logic [1:0]               mode_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] level_q;
  logic [15:0]              decim_q;
  logic signed [DATA_W-1:0] prev_q;
  logic                     prev_valid_q;
  logic                     pending_q;
  logic [15:0]              fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]        wr_ptr_q;

  logic                     frame_start, watched, trig_hit, start, keep, we;
  logic signed [DATA_W-1:0] cur;

  // Trigger comparison, frame-decimation bookkeeping and RAM write enable.
  always_comb begin
    cur         = s_axis_tdata;
    frame_start = s_axis_tvalid && (s_axis_tuser == '0);
    watched     = s_axis_tvalid && (s_axis_tuser == ch_q);
    trig_hit    = 1'b0;
    if (watched && prev_valid_q) begin
      if (mode_q == TRIG_RISE) begin
        trig_hit = (prev_q < level_q) && (cur >= level_q);
      end else if (mode_q == TRIG_FALL) begin
        trig_hit = (prev_q > level_q) && (cur <= level_q);
      end
    end
    // The frame start that completes a trigger is itself the first stored beat.
    start  = (state_q == ARMED) && frame_start && (pending_q || trig_hit);
    fcnt_d = fcnt_q;
    keep   = (fcnt_q == '0);
    if (frame_start) begin
      fcnt_d = (fcnt_q == decim_q) ? '0 : fcnt_q + 16'd1;
      keep   = (fcnt_d == '0);
    end
    we = !abort && (start || ((state_q == CAPTURE) && s_axis_tvalid && keep));
  end

  // Control FSM with registered busy/done.
  always_ff @(posedge aclk_0 or negedge aresetn_0) begin
    if (!aresetn_0) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mode_q       <= TRIG_IMM;
      ch_q         <= '0;
      level_q      <= '0;
      decim_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      fcnt_q       <= '0;
      wr_ptr_q     <= '0;
    end else if (abort) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q      <= ARMED;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            mode_q       <= trig_mode;
            ch_q         <= trig_ch;
            level_q      <= trig_level;
            decim_q      <= decim;
            prev_valid_q <= 1'b0;
            pending_q    <= trig_is_immediate(trig_mode);
            fcnt_q       <= '0;
            wr_ptr_q     <= '0;
          end
        end
        ARMED: begin
          if (watched) begin
            prev_q       <= cur;
            prev_valid_q <= 1'b1;
          end
          if (trig_hit) begin
            pending_q <= 1'b1;
          end
          if (start) begin
            state_q   <= CAPTURE;
            pending_q <= 1'b0;
            fcnt_q    <= '0;
            wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
          end
        end
        CAPTURE: begin
          fcnt_q <= fcnt_d;
          if (we) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (aclk_0),
    .rst_ni  (aresetn_0),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis_tdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign s_axis_tready = 1'b1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign trig_addr     = '0;

endmodule

// File: tb/tb_fir_stream_capture.sv
// Directed self-checking bench for fir_stream_capture (DEPTH=16, 2-bit-capable TDM).
module tb_fir_stream_capture;

  localparam int AW = 4;

  logic        aclk_0 = 1'b0;
  logic        aresetn_0;
  logic [31:0] s_axis_tdata;
  logic [0:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        arm, abort;
  logic [1:0]  trig_mode;
  logic [0:0]  trig_ch;
  logic [31:0] trig_level;
  logic [15:0] decim;
  logic [AW-1:0] rd_addr;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [AW-1:0] trig_addr;

  int checks   = 0;
  int failures = 0;

  fir_stream_capture #(
    .DATA_W (32),
    .NUM_CH (2),
    .CH_W   (1),
    .DEPTH  (16),
    .ADDR_W (AW)
  ) dut (
    .aclk_0        (aclk_0),
    .aresetn_0     (aresetn_0),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .abort         (abort),
    .trig_mode     (trig_mode),
    .trig_ch       (trig_ch),
    .trig_level    (trig_level),
    .decim         (decim),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .trig_addr     (trig_addr)
  );

  always #5 aclk_0 = ~aclk_0;

  task automatic tick();
    @(posedge aclk_0);
    #1;
  endtask

  task automatic beat(input logic v, input logic u, input logic [31:0] d);
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tdata  = d;
    tick();
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    s_axis_tvalid = 1'b0;
    rd_addr = AW'(a);
    tick();
    d = rd_data;
  endtask

  task automatic start(input logic [1:0] m, input logic c, input logic [31:0] lvl,
                       input logic [15:0] dc);
    trig_mode = m; trig_ch = c; trig_level = lvl; decim = dc;
    s_axis_tvalid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    s_axis_tvalid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    aresetn_0 = 1'b0;
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tdata = 0;
    arm = 0; abort = 0; trig_mode = 0; trig_ch = 0; trig_level = 0; decim = 0; rd_addr = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%0b exp=1", s_axis_tready); end
    checks++; if (trig_addr !== '0) begin failures++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
    aresetn_0 = 1'b1;
    tick();
  endtask

  task automatic test_immediate();
    logic [31:0] d;
    int bad_i = -1;
    trig_mode = 0; trig_ch = 0; trig_level = 0; decim = 0;
    for (int i = 0; i < 31; i++) begin
      arm = (i == 5);
      beat(1'b1, 1'b0, 32'(i));
      arm = 1'b0;
      if (bad_i < 0 && busy !== ((i >= 5) && (i < 21))) bad_i = i;
      if (i == 20) begin
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL imm_done_early got=%0b exp=0", done); end
      end
      if (i == 21) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL imm_done got=%0b exp=1", done); end
      end
    end
    checks++; if (bad_i >= 0) begin failures++; $display("FAIL imm_busy_window got=wrong_at_sample_%0d exp=high_5_to_20", bad_i); end
    for (int k = 0; k < 16; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(6 + k)) begin failures++; $display("FAIL imm_word[%0d] got=%0d exp=%0d", k, d, 6 + k); end
    end
  endtask

  task automatic test_rising();
    logic [31:0] d;
    int v1[6] = '{-3, -1, 2, 5, -4, 1};
    int e1[4] = '{2, 5, -4, 1};
    int v2[6] = '{2, 5, -4, 1, 7, 8};
    int e2[3] = '{1, 7, 8};
    start(2'd1, 1'b0, 32'd0, 16'd0);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rise_arm_flags got=busy%0b_done%0b exp=busy1_done0", busy, done); end
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 32'(v1[i]));
    for (int k = 0; k < 4; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(e1[k])) begin failures++; $display("FAIL rise_word[%0d] got=%0d exp=%0d", k, $signed(d), e1[k]); end
    end
    do_abort();
    start(2'd1, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 32'(v2[i]));
    for (int k = 0; k < 3; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(e2[k])) begin failures++; $display("FAIL rise_noprev_word[%0d] got=%0d exp=%0d", k, $signed(d), e2[k]); end
    end
    do_abort();
  endtask

  task automatic test_decim();
    logic [31:0] d;
    start(2'd0, 1'b0, 32'd0, 16'd3);
    for (int i = 0; i < 64; i++) beat(1'b1, 1'b0, 32'(i));
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL decim_done got=%0b exp=1", done); end
    for (int k = 0; k < 16; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(4 * k)) begin failures++; $display("FAIL decim_word[%0d] got=%0d exp=%0d", k, d, 4 * k); end
    end
  endtask

  task automatic test_falling_2ch();
    logic [31:0] d;
    start(2'd2, 1'b1, -32'sd10, 16'd0);
    for (int n = 0; n < 20; n++) begin
      beat(1'b1, 1'b0, 32'(n));
      beat(1'b1, 1'b1, 32'(-n));
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fall_done got=%0b exp=1", done); end
    for (int j = 0; j < 8; j++) begin
      rd(2 * j, d);
      checks++; if (d !== 32'(11 + j)) begin failures++; $display("FAIL fall_ch0[%0d] got=%0d exp=%0d", j, $signed(d), 11 + j); end
      rd(2 * j + 1, d);
      checks++; if (d !== 32'(-(11 + j))) begin failures++; $display("FAIL fall_ch1[%0d] got=%0d exp=%0d", j, $signed(d), -(11 + j)); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    start(2'd0, 1'b0, 32'd0, 16'd0);
    beat(1'b1, 1'b0, 32'd200);
    beat(1'b1, 1'b0, 32'd201);
    arm = 1'b1;
    beat(1'b1, 1'b0, 32'd202);
    arm = 1'b0;
    beat(1'b1, 1'b0, 32'd203);
    beat(1'b1, 1'b0, 32'd204);
    rd(0, d);
    checks++; if (d !== 32'd200) begin failures++; $display("FAIL abort_arm_ignored_w0 got=%0d exp=200", d); end
    rd(3, d);
    checks++; if (d !== 32'd203) begin failures++; $display("FAIL abort_arm_ignored_w3 got=%0d exp=203", d); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%0b exp=1", busy); end
    do_abort();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle got=busy%0b_done%0b exp=busy0_done0", busy, done); end
    start(2'd0, 1'b0, 32'd0, 16'd0);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 32'(300 + i));
    for (int k = 0; k < 4; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(300 + k)) begin failures++; $display("FAIL abort_rearm_word[%0d] got=%0d exp=%0d", k, d, 300 + k); end
    end
    rd(4, d);
    checks++; if (d !== 32'd204) begin failures++; $display("FAIL abort_old_word4 got=%0d exp=204", d); end
    do_abort();
    abort = 1'b1; arm = 1'b1; s_axis_tvalid = 1'b0;
    tick();
    abort = 1'b0; arm = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_wins_over_arm got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    start(2'd0, 1'b0, 32'd0, 16'd0);
    beat(1'b1, 1'b0, 32'd500);
    beat(1'b1, 1'b0, 32'd501);
    beat(1'b1, 1'b0, 32'd502);
    s_axis_tvalid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%0b exp=1", busy); end
    @(negedge aclk_0);
    aresetn_0 = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_async got=busy%0b_done%0b exp=busy0_done0", busy, done); end
    tick();
    aresetn_0 = 1'b1;
    tick();
    rd(1, d);
    checks++; if (d !== 32'd501) begin failures++; $display("FAIL rstmid_ram_kept got=%0d exp=501", d); end
  endtask

  task automatic test_gaps();
    logic [31:0] d;
    logic [15:0] pat = 16'hB2E5;
    logic v;
    int cnt = 0;
    int tready_bad = 0;
    start(2'd0, 1'b0, 32'd0, 16'd0);
    for (int c = 0; c < 200 && done !== 1'b1; c++) begin
      v = pat[c % 16];
      beat(v, 1'b0, v ? 32'(1000 + cnt) : 32'hDEAD_BEEF);
      if (v) cnt++;
      if (s_axis_tready !== 1'b1) tready_bad++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gaps_done_timeout got=%0b exp=1", done); end
    checks++; if (tready_bad != 0) begin failures++; $display("FAIL gaps_tready got=low_%0d_cycles exp=always_1", tready_bad); end
    for (int k = 0; k < 16; k++) begin
      rd(k, d);
      checks++; if (d !== 32'(1000 + k)) begin failures++; $display("FAIL gaps_word[%0d] got=%0d exp=%0d", k, d, 1000 + k); end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_rising();
    test_decim();
    test_falling_2ch();
    test_abort();
    test_reset_mid();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=still_running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
